// File: rtl/igual_lock_tracker.sv
// igual_lock_tracker: run-length lock detector for the 2-bit equality comparator.
//   Accepts eq_in when eq_valid && eq_ready. LOCK is declared after LOCK_N
//   consecutive matches. LOCK is dropped after LOSS_N consecutive mismatches,
//   with a one-cycle HOLD that accepts no sample. Match and mismatch totals
//   saturate at their maximum value.
// Optional feature: define IGUAL_STICKY_LOCK_EN to make LOCK terminal. In that
//   build only rst or clear leaves LOCK, and loss_evt is tied to 0.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   eq_valid, eq_in    sample strobe and comparator result (1 = equal)
//   eq_ready           stage accepts a sample this cycle
//   clear              synchronous soft clear of state and counters
//   locked             high while in LOCK
//   lock_evt, loss_evt one-cycle pulses on SEARCH->LOCK and LOCK->HOLD
//   run_len            current consecutive run length
//   match_tot          saturating count of accepted matches
//   miss_tot           saturating count of accepted mismatches
// All outputs are registered.
module igual_lock_tracker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSS_N = 2,
  parameter int unsigned RUN_W  = 4,
  parameter int unsigned TOT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eq_valid,
  input  logic             eq_in,
  output logic             eq_ready,
  input  logic             clear,
  output logic             locked,
  output logic             lock_evt,
  output logic             loss_evt,
  output logic [RUN_W-1:0] run_len,
  output logic [TOT_W-1:0] match_tot,
  output logic [TOT_W-1:0] miss_tot
);

  localparam int unsigned CNT_W = RUN_W + 1;
  localparam logic [CNT_W-1:0] LOCK_THR = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] LOSS_THR = CNT_W'(LOSS_N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCK   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               eq_ready_q, eq_ready_d;
  logic               locked_q, locked_d;
  logic               lock_evt_q, lock_evt_d;
  logic               loss_evt_q, loss_evt_d;
  logic [RUN_W-1:0]   run_len_q, run_len_d;
  logic [TOT_W-1:0]   match_tot_q, match_tot_d;
  logic [TOT_W-1:0]   miss_tot_q, miss_tot_d;
  logic               accept_c;
  logic [CNT_W-1:0]   run_inc_c;

  // eq_ready_q mirrors the current state, so it qualifies acceptance directly.
  assign accept_c  = eq_valid && eq_ready_q;
  // One extra bit so the threshold compare cannot alias on overflow.
  assign run_inc_c = CNT_W'(run_len_q) + CNT_W'(1);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      eq_ready_q  <= 1'b0;
      locked_q    <= 1'b0;
      lock_evt_q  <= 1'b0;
      loss_evt_q  <= 1'b0;
      run_len_q   <= '0;
      match_tot_q <= '0;
      miss_tot_q  <= '0;
    end else begin
      state_q     <= state_d;
      eq_ready_q  <= eq_ready_d;
      locked_q    <= locked_d;
      lock_evt_q  <= lock_evt_d;
      loss_evt_q  <= loss_evt_d;
      run_len_q   <= run_len_d;
      match_tot_q <= match_tot_d;
      miss_tot_q  <= miss_tot_d;
    end
  end

  // Next-state, run-length and totals
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    match_tot_d = match_tot_q;
    miss_tot_d  = miss_tot_q;
    lock_evt_d  = 1'b0;
    loss_evt_d  = 1'b0;

    if (clear) begin
      // Clear overrides everything; a coincident sample is dropped.
      state_d     = ST_SEARCH;
      run_len_d   = '0;
      match_tot_d = '0;
      miss_tot_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (accept_c) begin
            if (eq_in) begin
              if (run_inc_c == LOCK_THR) begin
                state_d    = ST_LOCK;
                run_len_d  = '0;
                lock_evt_d = 1'b1;
              end else begin
                run_len_d = run_inc_c[RUN_W-1:0];
              end
            end else begin
              run_len_d = '0;
            end
          end
        end
        ST_LOCK: begin
          if (accept_c) begin
            if (!eq_in) begin
`ifdef IGUAL_STICKY_LOCK_EN
              // Terminal LOCK: the mismatch run saturates just below LOSS_N.
              if (run_inc_c < LOSS_THR) begin
                run_len_d = run_inc_c[RUN_W-1:0];
              end
`else
              if (run_inc_c == LOSS_THR) begin
                state_d    = ST_HOLD;
                run_len_d  = '0;
                loss_evt_d = 1'b1;
              end else begin
                run_len_d = run_inc_c[RUN_W-1:0];
              end
`endif
            end else begin
              run_len_d = '0;
            end
          end
        end
        ST_HOLD: state_d = ST_SEARCH;
        default: state_d = ST_IDLE;
      endcase

      // Totals count every accepted sample and saturate without wrapping.
      if (accept_c) begin
        if (eq_in) begin
          if (match_tot_q != {TOT_W{1'b1}}) begin
            match_tot_d = match_tot_q + TOT_W'(1);
          end
        end else begin
          if (miss_tot_q != {TOT_W{1'b1}}) begin
            miss_tot_d = miss_tot_q + TOT_W'(1);
          end
        end
      end
    end

    eq_ready_d = (state_d == ST_SEARCH) || (state_d == ST_LOCK);
    locked_d   = (state_d == ST_LOCK);
  end

  assign eq_ready  = eq_ready_q;
  assign locked    = locked_q;
  assign lock_evt  = lock_evt_q;
  assign loss_evt  = loss_evt_q;
  assign run_len   = run_len_q;
  assign match_tot = match_tot_q;
  assign miss_tot  = miss_tot_q;

endmodule

// File: tb/tb_igual_lock_tracker.sv
// tb_igual_lock_tracker: directed self-checking bench for igual_lock_tracker
// with default parameters (LOCK_N=4, LOSS_N=2, RUN_W=4, TOT_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_igual_lock_tracker;

  logic       clk;
  logic       rst;
  logic       eq_valid;
  logic       eq_in;
  logic       eq_ready;
  logic       clear;
  logic       locked;
  logic       lock_evt;
  logic       loss_evt;
  logic [3:0] run_len;
  logic [7:0] match_tot;
  logic [7:0] miss_tot;

  int unsigned n_checks;
  int unsigned n_errors;

  igual_lock_tracker #(
    .LOCK_N(4),
    .LOSS_N(2),
    .RUN_W (4),
    .TOT_W (8)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .eq_valid (eq_valid),
    .eq_in    (eq_in),
    .eq_ready (eq_ready),
    .clear    (clear),
    .locked   (locked),
    .lock_evt (lock_evt),
    .loss_evt (loss_evt),
    .run_len  (run_len),
    .match_tot(match_tot),
    .miss_tot (miss_tot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for one rising edge; return at the following falling edge.
  task automatic step(input logic v, input logic d);
    eq_valid = v;
    eq_in    = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pat;
    logic       seen_loss;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    eq_valid = 1'b0;
    eq_in    = 1'b0;
    clear    = 1'b0;

    // Power-on reset and release
    repeat (2) @(negedge clk);
    check("por_ready", 32'(eq_ready), 32'd0);
    check("por_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    #1 check("release_ready_still0", 32'(eq_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(eq_ready), 32'd1);

    // Lock acquisition: four matches
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1);
      check("acq_locked_early", 32'(locked), 32'd0);
      check("acq_run_len", 32'(run_len), 32'(i));
    end
    step(1'b1, 1'b1);
    check("acq_locked", 32'(locked), 32'd1);
    check("acq_lock_evt", 32'(lock_evt), 32'd1);
    check("acq_run_len0", 32'(run_len), 32'd0);
    check("acq_match_tot", 32'(match_tot), 32'd4);
    step(1'b0, 1'b0);
    check("acq_lock_evt_pulse", 32'(lock_evt), 32'd0);
    check("acq_locked_hold", 32'(locked), 32'd1);

    // Loss and HOLD recovery
    step(1'b1, 1'b0);
    check("loss_run_len1", 32'(run_len), 32'd1);
    check("loss_locked_still", 32'(locked), 32'd1);
    check("loss_evt_early", 32'(loss_evt), 32'd0);
    step(1'b1, 1'b0);
    check("loss_evt", 32'(loss_evt), 32'd1);
    check("loss_locked", 32'(locked), 32'd0);
    check("hold_ready", 32'(eq_ready), 32'd0);
    check("loss_miss_tot", 32'(miss_tot), 32'd2);
    check("loss_run_len0", 32'(run_len), 32'd0);
    step(1'b1, 1'b1);  // offered during HOLD, must be ignored
    check("hold_ignored_match", 32'(match_tot), 32'd4);
    check("hold_ignored_run", 32'(run_len), 32'd0);
    check("search_ready", 32'(eq_ready), 32'd1);
    check("loss_evt_pulse", 32'(loss_evt), 32'd0);

    // Mid-cycle asynchronous reset with a sample pending
    eq_valid = 1'b1;
    eq_in    = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(eq_ready), 32'd0);
    check("arst_match_tot", 32'(match_tot), 32'd0);
    check("arst_miss_tot", 32'(miss_tot), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    eq_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_ready_back", 32'(eq_ready), 32'd1);

    // Broken run: 1,1,1,0,1,1,1,1 (first sample is bit 7)
    pat = 8'b1110_1111;
    for (int i = 7; i >= 1; i--) begin
      step(1'b1, pat[i]);
      check("brk_no_lock", 32'(locked), 32'd0);
    end
    check("brk_run_len3", 32'(run_len), 32'd3);
    step(1'b1, pat[0]);
    check("brk_locked", 32'(locked), 32'd1);
    check("brk_lock_evt", 32'(lock_evt), 32'd1);
    check("brk_miss_tot", 32'(miss_tot), 32'd1);
    check("brk_match_tot", 32'(match_tot), 32'd7);

    // Clear while locked, with a coincident match
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    check("clr_locked", 32'(locked), 32'd0);
    check("clr_match_tot", 32'(match_tot), 32'd0);
    check("clr_miss_tot", 32'(miss_tot), 32'd0);
    check("clr_run_len", 32'(run_len), 32'd0);
    check("clr_lock_evt", 32'(lock_evt), 32'd0);
    check("clr_ready", 32'(eq_ready), 32'd1);

    // Saturation: 300 matches
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
    check("sat_match_tot", 32'(match_tot), 32'd255);
    check("sat_miss_tot", 32'(miss_tot), 32'd0);
    check("sat_locked", 32'(locked), 32'd1);

`ifdef IGUAL_STICKY_LOCK_EN
    // Sticky lock: ten mismatches never leave LOCK
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("sticky_locked_in", 32'(locked), 32'd1);
    seen_loss = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (loss_evt) seen_loss = 1'b1;
    end
    check("sticky_locked", 32'(locked), 32'd1);
    check("sticky_miss_tot", 32'(miss_tot), 32'd10);
    check("sticky_run_len", 32'(run_len), 32'd1);
    check("sticky_no_loss", 32'(seen_loss), 32'd0);
`else
    // Non-sticky: a single mismatch then a match keeps LOCK and resets the run
    seen_loss = 1'b0;
    step(1'b1, 1'b0);
    if (loss_evt) seen_loss = 1'b1;
    step(1'b1, 1'b1);
    if (loss_evt) seen_loss = 1'b1;
    check("relock_run_len", 32'(run_len), 32'd0);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_no_loss", 32'(seen_loss), 32'd0);
    check("relock_miss_tot", 32'(miss_tot), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
